// File: rtl/mem_stage_ctrl_pkg.sv
// Shared encodings for the memory-stage controller: access types, FSM states,
// AXI-lite response coding, and the alignment / byte-lane helpers.
package mem_stage_ctrl_pkg;

    typedef enum logic [2:0] {
        MT_B  = 3'd0,
        MT_H  = 3'd1,
        MT_W  = 3'd2,
        MT_BU = 3'd3,
        MT_HU = 3'd4
    } mtype_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WREQ  = 3'd3,
        S_WRESP = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    localparam logic RESP_ERR = 1'b1;

    function automatic logic is_half(input logic [2:0] mt);
        return (mt == MT_H) || (mt == MT_HU);
    endfunction

    function automatic logic misaligned(input logic [2:0] mt, input logic [1:0] ofs);
        return (is_half(mt) && ofs[0]) || ((mt == MT_W) && (ofs != 2'b00));
    endfunction

    function automatic logic [3:0] lane_strb(input logic [2:0] mt, input logic [1:0] ofs);
        if (mt == MT_W)
            return 4'b1111;
        else if (is_half(mt))
            return 4'b0011 << ofs;
        else
            return 4'b0001 << ofs;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_ld_ext.sv
// Load-data aligner: moves the addressed byte/half down to bit 0 and extends it
// according to the access type.
module ld_ext
    import mem_stage_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  ofs,
    input  logic [2:0]  mtype,
    output logic [31:0] data
);

    logic [31:0]        shifted;
    logic signed [7:0]  sbyte;
    logic signed [15:0] shalf;
    logic signed [31:0] sbyte_ext;
    logic signed [31:0] shalf_ext;

    always_comb begin
        shifted   = rdata >> {ofs, 3'b000};
        sbyte     = shifted[7:0];
        shalf     = shifted[15:0];
        sbyte_ext = sbyte;
        shalf_ext = shalf;
        data      = shifted;
        case (mtype)
            MT_B:    data = sbyte_ext;
            MT_H:    data = shalf_ext;
            MT_BU:   data = {24'b0, shifted[7:0]};
            MT_HU:   data = {16'b0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: turns one execute-stage load/store request into an
// AXI-lite transaction and hands the (extended) result to writeback.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        in_load,
    input  logic        in_store,
    input  logic [2:0]  in_mtype,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bresp,
    input  logic        bvalid,
    output logic        bready
);

    state_e      state, state_nx;
    logic        run;
    logic        aw_pend, w_pend;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  mtype_q;
    logic [31:0] ld_data;
    logic        accept, bad_req, is_mem, aw_left, w_left;

    assign accept  = in_valid && in_ready;
    assign is_mem  = in_load || in_store;
    assign bad_req = (in_load && in_store) ||
                     (is_mem && ((in_mtype > 3'd4) || misaligned(in_mtype, in_addr[1:0])));
    assign aw_left = aw_pend && !awready;
    assign w_left  = w_pend && !wready;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (bad_req || !is_mem) state_nx = S_DONE;
                    else if (in_load)       state_nx = S_RADDR;
                    else                    state_nx = S_WREQ;
                end
            end
            S_RADDR: if (arready) state_nx = S_RDATA;
            S_RDATA: if (rvalid) state_nx = S_DONE;
            // The two write channels finish independently; both may close in one cycle.
            S_WREQ:  if (!aw_left && !w_left) state_nx = S_WRESP;
            S_WRESP: if (bvalid) state_nx = S_DONE;
            S_DONE:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // run keeps in_ready low for the whole reset period even though state is already IDLE.
    assign in_ready  = (state == S_IDLE) && run;
    assign arvalid   = (state == S_RADDR);
    assign rready    = (state == S_RDATA);
    assign awvalid   = (state == S_WREQ) && aw_pend;
    assign wvalid    = (state == S_WREQ) && w_pend;
    assign bready    = (state == S_WRESP);
    assign out_valid = (state == S_DONE);
    assign araddr    = {addr_q[31:2], 2'b00};
    assign awaddr    = {addr_q[31:2], 2'b00};
    assign wdata     = wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            run       <= 1'b0;
            aw_pend   <= 1'b0;
            w_pend    <= 1'b0;
            wstrb     <= 4'b0;
            out_rdata <= 32'b0;
            out_err   <= 1'b0;
        end else begin
            run <= 1'b1;
            if (accept) begin
                aw_pend   <= in_store;
                w_pend    <= in_store;
                wstrb     <= lane_strb(in_mtype, in_addr[1:0]);
                out_rdata <= 32'b0;
                out_err   <= bad_req;
            end
            if (state == S_WREQ) begin
                if (awready) aw_pend <= 1'b0;
                if (wready)  w_pend  <= 1'b0;
            end
            if ((state == S_RDATA) && rvalid) begin
                out_rdata <= ld_data;
                out_err   <= (rresp == RESP_ERR);
            end
            if ((state == S_WRESP) && bvalid)
                out_err <= (bresp == RESP_ERR);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= in_addr;
            wdata_q <= in_wdata << {in_addr[1:0], 3'b000};
            mtype_q <= in_mtype;
        end
    end

    ld_ext u_ld_ext (
        .rdata (rdata),
        .ofs   (addr_q[1:0]),
        .mtype (mtype_q),
        .data  (ld_data)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized bench for mem_stage_ctrl with a behavioural AXI-lite slave and a
// transaction-level model of the expected result, bus traffic and latency.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_load, in_store;
    logic [31:0] in_addr, in_wdata;
    logic [2:0]  in_mtype;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_rdata;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rresp, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bresp, bvalid, bready;
    logic [3:0]  wstrb;

    int n_chk = 0;
    int n_err = 0;

    // transaction descriptor consumed by run_txn
    logic        t_ld, t_st, t_rresp, t_bresp, t_noise;
    logic [2:0]  t_mt;
    logic [31:0] t_addr, t_wd, t_rd;
    int          t_ard, t_rdd, t_awd, t_wdd, t_bd, t_od;

    always #5 clk = ~clk;

    mem_stage_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_load(in_load), .in_store(in_store), .in_mtype(in_mtype),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] mt);
        case (mt)
            3'd0, 3'd3: return 1;
            3'd1, 3'd4: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    task automatic slave_idle();
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; out_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        @(negedge clk); @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic run_txn();
        logic        fault, bus, done;
        logic [31:0] e_rd, exp_addr, exp_wd;
        logic [3:0]  exp_strb;
        logic        e_err;
        longint      v;
        int size, ofs, e_lat, cyc, first_ov, busy_ir;
        int arh, rh, awh, wh, bh, arc, rc, awc, wc, bc, oc, aw_cnt, w_cnt;
        logic p_arv, p_rr, p_awv, p_wv, p_br, p_ov;
        logic [31:0] p_araddr, p_awaddr, p_wdata;
        logic [3:0]  p_wstrb;

        // expected outcome from the access rules
        ofs   = int'(t_addr[1:0]);
        size  = size_of(t_mt);
        fault = (t_ld && t_st) || ((t_ld || t_st) && (size == 0 || (ofs % size) != 0));
        bus   = (t_ld || t_st) && !fault;
        exp_addr = {t_addr[31:2], 2'b00};
        exp_strb = 4'(((1 << size) - 1) << ofs);
        exp_wd   = t_wd << (8 * ofs);
        if (t_ld && bus) begin
            v = longint'(t_rd >> (8 * ofs)) & ((64'd1 << (8 * size)) - 1);
            if (t_mt < 3 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                v = v - (longint'(1) << (8 * size));
            e_rd  = v[31:0];
            e_err = t_rresp;
            e_lat = 3 + t_ard + t_rdd;
        end else if (t_st && bus) begin
            e_rd  = 0;
            e_err = t_bresp;
            e_lat = 3 + ((t_awd > t_wdd) ? t_awd : t_wdd) + t_bd;
        end else begin
            e_rd  = 0;
            e_err = fault;
            e_lat = 1;
        end

        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        chk("accept_ready", 32'(in_ready), 1);
        in_valid = 1; in_load = t_ld; in_store = t_st; in_mtype = t_mt;
        in_addr = t_addr; in_wdata = t_wd;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0; in_addr = $urandom; in_wdata = $urandom;
        in_load = 1'($urandom); in_store = 1'($urandom); in_mtype = 3'($urandom);

        arh = 0; rh = 0; awh = 0; wh = 0; bh = 0;
        arc = 0; rc = 0; awc = 0; wc = 0; bc = 0; oc = 0; aw_cnt = 0; w_cnt = 0;
        p_arv = 0; p_rr = 0; p_awv = 0; p_wv = 0; p_br = 0; p_ov = 0;
        p_araddr = 0; p_awaddr = 0; p_wdata = 0; p_wstrb = 0;
        first_ov = -1; busy_ir = 0; done = 0; cyc = 1;

        while (!done && cyc < 300) begin
            // handshakes that completed at the edge just passed
            if (p_arv && arready) begin arh++; chk("araddr", p_araddr, exp_addr); end
            if (p_rr && rvalid) rh++;
            if (p_awv && awready) begin awh++; chk("awaddr", p_awaddr, exp_addr); end
            if (p_wv && wready) begin
                wh++;
                chk("wdata", p_wdata, exp_wd);
                chk("wstrb", 32'(p_wstrb), 32'(exp_strb));
            end
            if (p_br && bvalid) bh++;
            if (p_ov && out_ready) done = 1;
            if (!done) begin
                p_arv = arvalid; p_rr = rready; p_awv = awvalid; p_wv = wvalid;
                p_br = bready; p_ov = out_valid;
                p_araddr = araddr; p_awaddr = awaddr; p_wdata = wdata; p_wstrb = wstrb;
                if (in_ready) busy_ir++;
                if (awvalid) aw_cnt++;
                if (wvalid) w_cnt++;
                if (out_valid) begin
                    if (first_ov < 0) first_ov = cyc;
                    oc++;
                    chk("out_rdata", out_rdata, e_rd);
                    chk("out_err", 32'(out_err), 32'(e_err));
                end
                arready = arvalid && (arc >= t_ard);
                if (arvalid) arc++;
                if (arh > 0 && rh == 0) begin
                    rvalid = (rc >= t_rdd); rc++; rdata = t_rd; rresp = t_rresp;
                end else begin
                    rvalid = t_noise & 1'($urandom); rdata = $urandom; rresp = 1'($urandom);
                end
                awready = awvalid && (awc >= t_awd);
                if (awvalid) awc++;
                wready = wvalid && (wc >= t_wdd);
                if (wvalid) wc++;
                if (awh > 0 && wh > 0 && bh == 0) begin
                    bvalid = (bc >= t_bd); bc++; bresp = t_bresp;
                end else begin
                    bvalid = t_noise & 1'($urandom); bresp = 1'($urandom);
                end
                out_ready = out_valid && (oc > t_od);
                cyc++;
                @(negedge clk);
            end
        end
        slave_idle();

        chk("complete", 32'(done), 1);
        chk("latency", first_ov, e_lat);
        chk("ar_hs", arh, 32'(bus && t_ld));
        chk("r_hs", rh, 32'(bus && t_ld));
        chk("aw_hs", awh, 32'(bus && t_st));
        chk("w_hs", wh, 32'(bus && t_st));
        chk("b_hs", bh, 32'(bus && t_st));
        chk("busy_in_ready", busy_ir, 0);
        if (bus && t_st) begin
            chk("aw_cycles", aw_cnt, t_awd + 1);
            chk("w_cycles", w_cnt, t_wdd + 1);
        end
        if (bus && t_ld) chk("ar_cycles", arc, t_ard + 1);
        if (done) chk("idle_after", 32'(in_ready), 1);
        else do_reset();
    endtask

    task automatic set_txn(input logic ld, input logic st, input logic [2:0] mt,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd);
        t_ld = ld; t_st = st; t_mt = mt; t_addr = addr; t_wd = wd; t_rd = rd;
        t_rresp = 0; t_bresp = 0; t_noise = 0;
        t_ard = 0; t_rdd = 0; t_awd = 0; t_wdd = 0; t_bd = 0; t_od = 0;
    endtask

    initial begin
        int kind, seen;
        rst = 1; in_valid = 0; in_load = 0; in_store = 0; in_mtype = 0;
        in_addr = 0; in_wdata = 0;
        slave_idle();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", 32'({in_ready, out_valid, arvalid, rready, awvalid, wvalid, bready, out_err}), 0);
        chk("rst_rdata", out_rdata, 0);
        chk("rst_wstrb", 32'(wstrb), 0);
        rst = 0;
        @(negedge clk);
        chk("ready_after_rst", 32'(in_ready), 1);

        // lb, sign-extended top byte, zero-wait
        set_txn(1, 0, 3'd0, 32'h8000_0003, 0, 32'h80FF_FFFF); run_txn();
        // sh into the upper half
        set_txn(0, 1, 3'd1, 32'h8000_0002, 32'h0000_BEEF, 0); run_txn();
        // sw with slow write-address channel
        set_txn(0, 1, 3'd2, 32'h8000_0010, 32'h1234_5678, 0); t_awd = 3; run_txn();
        // misaligned lw
        set_txn(1, 0, 3'd2, 32'h8000_0001, 0, 32'hDEAD_BEEF); run_txn();
        // lhu with read error and stalled writeback
        set_txn(1, 0, 3'd4, 32'h8000_0002, 0, 32'hABCD_1234); t_rresp = 1; t_od = 5; run_txn();
        // load and store together, bad type, neither
        set_txn(1, 1, 3'd2, 32'h0000_0000, 0, 0); run_txn();
        set_txn(1, 0, 3'd6, 32'h0000_0004, 0, 0); run_txn();
        set_txn(0, 0, 3'd2, 32'h0000_0008, 0, 0); run_txn();
        // store error response
        set_txn(0, 1, 3'd0, 32'h0000_0001, 32'hFF, 0); t_bresp = 1; t_wdd = 2; run_txn();

        // reset while waiting for read data
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        in_valid = 1; in_load = 1; in_store = 0; in_mtype = 3'd2; in_addr = 32'h0000_0040;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        arready = 1;
        @(negedge clk);
        arready = 0;
        chk("in_rdata_phase", 32'(rready), 1);
        rst = 1;
        @(negedge clk);
        chk("rst_mid_ctrl", 32'({in_ready, out_valid, arvalid, rready, awvalid, wvalid, bready, out_err}), 0);
        chk("rst_mid_wstrb", 32'(wstrb), 0);
        rst = 0;
        rvalid = 1; rdata = 32'h5555_AAAA;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        rvalid = 0;
        chk("late_rvalid", seen, 0);
        chk("ready_after_abort", 32'(in_ready), 1);

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            set_txn(kind < 4 || kind == 9, (kind >= 4 && kind < 8) || kind == 9,
                    3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
            if (t_mt > 3'd4 && $urandom_range(0, 2) != 0) t_mt = 3'($urandom_range(0, 4));
            if (kind == 8) begin
                t_mt = 3'($urandom_range(0, 4));
                t_addr[1:0] = 2'b00;
            end
            t_rresp = 1'($urandom_range(0, 3) == 0);
            t_bresp = 1'($urandom_range(0, 3) == 0);
            t_noise = 1'($urandom);
            t_ard = $urandom_range(0, 3); t_rdd = $urandom_range(0, 3);
            t_awd = $urandom_range(0, 3); t_wdd = $urandom_range(0, 3);
            t_bd  = $urandom_range(0, 3); t_od  = $urandom_range(0, 3);
            run_txn();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
Parameters: none.
REQ-001 clk  in  1  sole clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 in_valid  in  1  request from execute stage valid.
REQ-004 in_ready  out  1  block accepts request.
REQ-005 in_addr  in  32  byte address.
REQ-006 in_wdata  in  32  store data, right-aligned.
REQ-007 in_load  in  1  request is load.
REQ-008 in_store  in  1  request is store.
REQ-009 in_mtype  in  3  0 byte, 1 half, 2 word, 3 byte-unsigned, 4 half-unsigned.
REQ-010 out_valid  out  1  result to writeback valid.
REQ-011 out_ready  in  1  writeback accepts result.
REQ-012 out_rdata  out  32  extended load data; 0 for non-loads.
REQ-013 out_err  out  1  access fault or misalignment.
REQ-014 araddr/arvalid  out  32/1; arready  in  1  AXI-lite read address.
REQ-015 rdata  in  32; rresp  in  1; rvalid  in  1; rready  out  1  read data (rresp=1 is error).
REQ-016 awaddr/awvalid  out  32/1; awready  in  1  write address.
REQ-017 wdata  out  32; wstrb  out  4; wvalid  out  1; wready  in  1  write data.
REQ-018 bresp  in  1; bvalid  in  1; bready  out  1  write response (bresp=1 is error).

Function
REQ-019 States IDLE, RADDR, RDATA, WREQ, WRESP, DONE; all outputs registered or decoded from state only.
REQ-020 in_ready=1 only in IDLE; request latched on in_valid&&in_ready.
REQ-021 From IDLE: load -> RADDR; store -> WREQ; neither -> DONE with out_rdata=0, out_err=0.
REQ-022 Both in_load and in_store, in_mtype>4, half with addr[0]=1, or word with addr[1:0]!=0 -> DONE with out_err=1, no bus transaction.
REQ-023 araddr/awaddr = {addr[31:2],2'b00}, held stable while the corresponding valid is high.
REQ-024 RADDR: arvalid=1 until arready; then RDATA with rready=1; on rvalid -> DONE, capturing data and rresp.
REQ-025 Load data = rdata >> (8*addr[1:0]), then sign-extended (types 0,1), zero-extended (3,4) or passed (2).
REQ-026 WREQ: awvalid and wvalid both asserted on entry; each drops independently after its handshake; leave for WRESP when both are done (same-cycle completion allowed).
REQ-027 wstrb: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; wdata = in_wdata << (8*addr[1:0]).
REQ-028 WRESP: bready=1; on bvalid -> DONE, out_err=bresp.
REQ-029 DONE: out_valid=1, out_rdata/out_err held until out_ready; then IDLE; next request is accepted no earlier than the following cycle.
REQ-030 Minimum latency with zero-wait slave: load acceptance at cycle 0, arvalid at cycle 1, r handshake at cycle 2, out_valid at cycle 3.
REQ-031 rvalid/bvalid arriving outside RDATA/WRESP are ignored.

Reset
REQ-032 While rst=1: state IDLE; in_ready=0; out_valid, arvalid, rready, awvalid, wvalid, bready, out_err=0; out_rdata, wstrb=0. in_ready=1 the first cycle after deassertion.
REQ-033 Reset mid-transaction abandons it; no completion is reported.

Structure
REQ-034 Shared package holds mtype encodings, state encoding and the AXI-lite resp error value.
REQ-035 Load alignment/extension lives in the sub-module ld_ext (combinational; shift plus extend).

Verification
REQ-036 lb at 0x8000_0003, rdata=0x80FF_FFFF, zero-wait -> out_rdata=0xFFFF_FF80, out_valid at cycle 3.
REQ-037 sh at 0x8000_0002, in_wdata=0x0000_BEEF -> wstrb=4'b1100, wdata=0xBEEF_0000, awaddr=0x8000_0000.
REQ-038 sw with awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, one bready handshake.
REQ-039 lw at 0x8000_0001 -> no arvalid, out_err=1 at cycle 1.
REQ-040 lhu with rresp=1 and out_ready low for 5 cycles -> out_err=1 held 5 cycles, then IDLE.
REQ-041 rst asserted while in RDATA -> all valids 0 next cycle; a late rvalid produces no out_valid.
